// File: rtl/ym3438_dbg_pkg.sv
// Shared types and constants for the YM3438 debug-chain capture block.
package ym3438_dbg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } cap_state_e;

  localparam int CHAIN_LEN_MIN = 2;
  localparam int CHAIN_LEN_MAX = 256;

  function automatic int cnt_width(input int len);
    return (len <= 2) ? 1 : $clog2(len);
  endfunction

endpackage

// File: rtl/ym3438_dbg_capture_if.sv
// Host-side word handshake of the debug capture block.
interface ym3438_dbg_capture_if #(
  parameter int CHAIN_LEN = 16
);

  logic [CHAIN_LEN-1:0] data_out;
  logic                 valid;
  logic                 ready;
  logic                 busy;
  logic                 overrun;

  modport master (
    output data_out,
    output valid,
    output busy,
    output overrun,
    input  ready
  );

  modport slave (
    input  data_out,
    input  valid,
    input  busy,
    input  overrun,
    output ready
  );

endinterface

// File: rtl/ym3438_dbg_deser.sv
// Shift register and bit counter; done pulses combinationally on the last sample.
module ym3438_dbg_deser
  import ym3438_dbg_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                 MCLK,
  input  logic                 rst,
  input  logic                 clr,
  input  logic                 sample,
  input  logic                 serial_in,
  output logic                 done,
  output logic [CHAIN_LEN-1:0] word
);

  localparam int CW = cnt_width(CHAIN_LEN);

  logic [CW-1:0]        cnt;
  logic [CHAIN_LEN-2:0] sr;

  // Only CHAIN_LEN-1 bits are stored; the final bit joins straight from serial_in.
  assign word = {sr, serial_in};
  assign done = sample && (cnt == CW'(CHAIN_LEN - 1));

  always_ff @(posedge MCLK) begin
    if (rst || clr) begin
      cnt <= '0;
      sr  <= '0;
    end else if (sample) begin
      sr  <= word[CHAIN_LEN-2:0];
      cnt <= done ? '0 : cnt + CW'(1);
    end
  end

endmodule

// File: rtl/ym3438_dbg_capture.sv
// Debug-chain tail capture: serial stream to parallel word with valid/ready.
// Optional sticky overrun flag: define YM3438_DBG_CAPTURE_OVERRUN_EN.
//
// state | meaning
// IDLE  | waiting for a load event (busy=0)
// SHIFT | sampling chain bits on c1 (busy=1)
module ym3438_dbg_capture
  import ym3438_dbg_pkg::*;
#(
  parameter int CHAIN_LEN = 16
) (
  input  logic                  MCLK,
  input  logic                  rst,
  input  logic                  c1,
  input  logic                  load,
  input  logic                  serial_in,
  ym3438_dbg_capture_if.master  host
);

  if (CHAIN_LEN < CHAIN_LEN_MIN || CHAIN_LEN > CHAIN_LEN_MAX) begin : g_len_check
    $error("CHAIN_LEN out of range");
  end

  cap_state_e           state_q, state_d;
  logic                 load_ev, sample_ev, done;
  logic [CHAIN_LEN-1:0] word;
  logic [CHAIN_LEN-1:0] data_q;
  logic                 valid_q;

  assign load_ev   = c1 && load;
  assign sample_ev = c1 && (state_q == SHIFT) && !load;

  ym3438_dbg_deser #(
    .CHAIN_LEN (CHAIN_LEN)
  ) u_deser (
    .MCLK      (MCLK),
    .rst       (rst),
    .clr       (load_ev),
    .sample    (sample_ev),
    .serial_in (serial_in),
    .done      (done),
    .word      (word)
  );

  always_ff @(posedge MCLK) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // A load event in SHIFT restarts the capture rather than completing it.
  always_comb begin
    state_d = state_q;
    if (state_q == IDLE) begin
      if (load_ev) state_d = SHIFT;
    end else begin
      if (load_ev)   state_d = SHIFT;
      else if (done) state_d = IDLE;
    end
  end

  always_ff @(posedge MCLK) begin
    if (rst) begin
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (done) begin
      data_q  <= word;
      valid_q <= 1'b1;
    end else if (valid_q && host.ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef YM3438_DBG_CAPTURE_OVERRUN_EN
  logic overrun_q;

  always_ff @(posedge MCLK) begin
    if (rst)                                  overrun_q <= 1'b0;
    else if (done && valid_q && !host.ready)  overrun_q <= 1'b1;
  end

  assign host.overrun = overrun_q;
`else
  assign host.overrun = 1'b0;
`endif

  assign host.data_out = data_q;
  assign host.valid    = valid_q;
  assign host.busy     = (state_q == SHIFT);

endmodule

// File: tb/tb_ym3438_dbg_capture.sv
// Bench for ym3438_dbg_capture (CHAIN_LEN=8) against a bit-queue reference model.
module tb_ym3438_dbg_capture;

  localparam int N = 8;

  logic MCLK = 1'b0;
  logic rst, c1, load, serial_in;

  ym3438_dbg_capture_if #(.CHAIN_LEN(N)) hif ();

  ym3438_dbg_capture #(.CHAIN_LEN(N)) dut (
    .MCLK      (MCLK),
    .rst       (rst),
    .c1        (c1),
    .load      (load),
    .serial_in (serial_in),
    .host      (hif)
  );

  always #5 MCLK = ~MCLK;

  int n_cmp  = 0;
  int n_fail = 0;

  // reference model state
  bit         m_busy;
  bit         m_valid;
  bit         m_ovr;
  bit [N-1:0] m_data;
  bit         m_bits[$];
  int         valid_rises;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input bit c1v, input bit ldv, input bit sb, input bit rdy, input bit rstv);
    bit         ld_ev, smp, comp, prev_valid;
    bit [N-1:0] w;
    @(negedge MCLK);
    c1 = c1v; load = ldv; serial_in = sb; hif.ready = rdy; rst = rstv;
    prev_valid = m_valid;
    ld_ev = c1v && ldv;
    smp   = c1v && m_busy && !ldv;
    comp  = smp && (m_bits.size() == N - 1);
    if (rstv) begin
      m_busy = 0; m_valid = 0; m_ovr = 0; m_data = '0; m_bits.delete();
    end else begin
      if (comp) begin
        w = '0;
        foreach (m_bits[i]) w = {w[N-2:0], m_bits[i]};
        w = {w[N-2:0], sb};
`ifdef YM3438_DBG_CAPTURE_OVERRUN_EN
        if (m_valid && !rdy) m_ovr = 1;
`endif
        m_data = w; m_valid = 1; m_busy = 0; m_bits.delete();
      end else if (m_valid && rdy) begin
        m_valid = 0;
      end
      if (ld_ev) begin
        m_bits.delete(); m_busy = 1;
      end else if (smp && !comp) begin
        m_bits.push_back(sb);
      end
    end
    if (m_valid && !prev_valid) valid_rises++;
    @(posedge MCLK);
    #1;
    check("data_out", 32'(hif.data_out), 32'(m_data));
    check("valid",    32'(hif.valid),    32'(m_valid));
    check("busy",     32'(hif.busy),     32'(m_busy));
    check("overrun",  32'(hif.overrun),  32'(m_ovr));
  endtask

  // chain load: c1 edge with load, then the c2 half-cycle
  task automatic chain_load(input bit rdy);
    step(1, 1, 0, rdy, 0);
    step(0, 0, 0, rdy, 0);
  endtask

  // send bits [from .. from+cnt-1] of v, MSB first, one per c1
  task automatic send_bits(input bit [N-1:0] v, input int from, input int cnt, input bit rdy);
    for (int i = from; i < from + cnt; i++) begin
      step(1, 0, v[N-1-i], rdy, 0);
      step(0, 0, $urandom_range(0, 1), rdy, 0);
    end
  endtask

  task automatic capture(input bit [N-1:0] v, input bit rdy);
    chain_load(rdy);
    send_bits(v, 0, N, rdy);
  endtask

  task automatic do_reset();
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0);
  endtask

  initial begin
    bit [N-1:0] v;
    rst = 1; c1 = 0; load = 0; serial_in = 0; hif.ready = 0;
    do_reset();
    check("reset_data", 32'(hif.data_out), 32'h0);
    check("reset_valid", 32'(hif.valid), 32'h0);

    // basic capture, ready high
    capture(8'hA5, 1);
    check("a5_word", 32'(hif.data_out), 32'hA5);

    // two captures without accept
    capture(8'h3C, 0);
    capture(8'hC3, 0);
    check("c3_word", 32'(hif.data_out), 32'hC3);
    check("c3_valid", 32'(hif.valid), 32'h1);
`ifdef YM3438_DBG_CAPTURE_OVERRUN_EN
    check("c3_ovr", 32'(hif.overrun), 32'h1);
`else
    check("c3_ovr", 32'(hif.overrun), 32'h0);
`endif

    // completion on the accept edge
    do_reset();
    capture(8'h96, 0);
    v = 8'(32'($urandom));
    chain_load(0);
    send_bits(v, 0, N - 1, 0);
    step(1, 0, v[0], 1, 0);
    check("same_edge_word", 32'(hif.data_out), 32'(v));
    check("same_edge_valid", 32'(hif.valid), 32'h1);
    check("same_edge_ovr", 32'(hif.overrun), 32'h0);
    step(0, 0, 0, 1, 0);

    // restart after 4 samples
    valid_rises = 0;
    chain_load(1);
    send_bits(8'hFF, 0, 4, 1);
    capture(8'h5A, 1);
    check("restart_word", 32'(hif.data_out), 32'h5A);
    check("restart_rises", 32'(valid_rises), 32'h1);

    // reset mid-capture
    chain_load(1);
    send_bits(8'h00, 0, 3, 1);
    do_reset();
    check("midrst_busy", 32'(hif.busy), 32'h0);
    check("midrst_data", 32'(hif.data_out), 32'h0);
    capture(8'hFF, 1);
    check("after_rst_word", 32'(hif.data_out), 32'hFF);

    // c1 stalled mid-capture
    chain_load(1);
    send_bits(8'hA5, 0, 4, 1);
    for (int i = 0; i < 20; i++) step(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 0);
    send_bits(8'hA5, 4, 4, 1);
    check("stall_word", 32'(hif.data_out), 32'hA5);

    // randomized captures, gaps, ready and restarts
    for (int t = 0; t < 30; t++) begin
      bit r;
      v = 8'(32'($urandom));
      r = $urandom_range(0, 1);
      chain_load(r);
      if ($urandom_range(0, 3) == 0) begin
        send_bits(8'(32'($urandom)), 0, $urandom_range(1, N - 1), r);
        chain_load(r);
      end
      for (int i = 0; i < N; i++) begin
        step(1, 0, v[N-1-i], $urandom_range(0, 1), 0);
        for (int g = 0; g < int'($urandom_range(1, 3)); g++)
          step(0, 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
      end
      check("rand_word", 32'(hif.data_out), 32'(v));
      for (int g = 0; g < int'($urandom_range(0, 3)); g++)
        step($urandom_range(0, 1), 0, $urandom_range(0, 1), $urandom_range(0, 1), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
